// File: rtl/video_timing_detector.sv
// Measures active width/height of a sync+blank video stream and asserts o_Locked once
// C_LOCK_FRAMES consecutive matching frames are seen. Define VIDEO_TIMING_DETECTOR_TOTALS_EN
// to also measure line/frame totals and include them in the lock decision.
module video_timing_detector #(
  parameter int C_COUNT_WIDTH = 12,
  parameter int C_LOCK_FRAMES = 2
) (
  input  logic                     i_Clk,
  input  logic                     i_nRst,
  input  logic                     i_nHSync,
  input  logic                     i_nVSync,
  input  logic                     i_HBlank,
  input  logic                     i_VBlank,
  output logic                     o_Locked,
  output logic [C_COUNT_WIDTH-1:0] o_Width,
  output logic [C_COUNT_WIDTH-1:0] o_Height,
  output logic [C_COUNT_WIDTH-1:0] o_HTotal,
  output logic [C_COUNT_WIDTH-1:0] o_VTotal
);
  typedef logic [C_COUNT_WIDTH-1:0] cnt_t;
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam cnt_t       MAX    = '1;
  localparam logic [3:0] LOCK_N = 4'(C_LOCK_FRAMES);

  function automatic cnt_t inc_sat(input cnt_t v);
    return (v == MAX) ? v : v + cnt_t'(1);
  endfunction

  logic   hs_q, vs_q, hb_q, vb_q, hs_prev, vs_prev;
  logic   hs_start, vs_start, timeout;
  cnt_t   h_cnt, w_cnt;
  logic   line_vact;
  cnt_t   v_cnt, act_cnt, ref_w;
  logic   ref_w_ok, incons;
  cnt_t   f_v, f_act, f_rw;
  logic   f_rw_ok, f_inc, frame_ok, frame_eq;
  cnt_t   prev_w, prev_h;
  logic   prev_ok;
  logic [3:0] match_cnt;
  state_t state;
`ifdef VIDEO_TIMING_DETECTOR_TOTALS_EN
  cnt_t   ref_t, f_rt, prev_ht, prev_vt;
  logic   ref_t_ok, f_rt_ok;
`endif

  assign hs_start = hs_prev & ~hs_q;
  assign vs_start = vs_prev & ~vs_q;
  // A saturated line counter coinciding with a real hsync edge is just a long line, not a loss.
  assign timeout  = (h_cnt == MAX) && !hs_start;

  // Input registers and per-line counters; history clears to 0 so an already-low sync is ignored.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hb_q      <= 1'b0;
      vb_q      <= 1'b0;
      hs_prev   <= 1'b0;
      vs_prev   <= 1'b0;
      h_cnt     <= '0;
      w_cnt     <= '0;
      line_vact <= 1'b0;
    end else begin
      hs_q    <= i_nHSync;
      vs_q    <= i_nVSync;
      hb_q    <= i_HBlank;
      vb_q    <= i_VBlank;
      hs_prev <= hs_q;
      vs_prev <= vs_q;
      if (hs_start) begin
        h_cnt     <= cnt_t'(1);
        w_cnt     <= hb_q ? '0 : cnt_t'(1);
        line_vact <= ~vb_q;
      end else begin
        h_cnt <= inc_sat(h_cnt);
        if (!hb_q) w_cnt <= inc_sat(w_cnt);
        if (!vb_q) line_vact <= 1'b1;
      end
    end
  end

  // Frame accumulators including the line completing this cycle, so a simultaneous
  // hsync/vsync start counts that line in the ending frame.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    f_v     = v_cnt;
    f_act   = act_cnt;
    f_rw    = ref_w;
    f_rw_ok = ref_w_ok;
    f_inc   = incons;
`ifdef VIDEO_TIMING_DETECTOR_TOTALS_EN
    f_rt    = ref_t;
    f_rt_ok = ref_t_ok;
`endif
    if (hs_start) begin
      f_v = inc_sat(v_cnt);
      if (line_vact && (w_cnt != '0)) f_act = inc_sat(act_cnt);
      if ((w_cnt == MAX) || (f_v == MAX) || (f_act == MAX)) f_inc = 1'b1;
      if (w_cnt != '0) begin
        if (!ref_w_ok) begin
          f_rw    = w_cnt;
          f_rw_ok = 1'b1;
        end else if (w_cnt != ref_w) begin
          f_inc = 1'b1;
        end
      end
`ifdef VIDEO_TIMING_DETECTOR_TOTALS_EN
      if (h_cnt == MAX) f_inc = 1'b1;
      if (!ref_t_ok) begin
        f_rt    = h_cnt;
        f_rt_ok = 1'b1;
      end else if (h_cnt != ref_t) begin
        f_inc = 1'b1;
      end
`endif
    end
    frame_ok = f_rw_ok && !f_inc;
    frame_eq = (f_rw == prev_w) && (f_act == prev_h);
`ifdef VIDEO_TIMING_DETECTOR_TOTALS_EN
    if ((f_rt != prev_ht) || (f_v != prev_vt)) frame_eq = 1'b0;
`endif
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      v_cnt    <= '0;
      act_cnt  <= '0;
      ref_w    <= '0;
      ref_w_ok <= 1'b0;
      incons   <= 1'b0;
`ifdef VIDEO_TIMING_DETECTOR_TOTALS_EN
      ref_t    <= '0;
      ref_t_ok <= 1'b0;
`endif
    end else if (vs_start) begin
      v_cnt    <= '0;
      act_cnt  <= '0;
      ref_w    <= '0;
      ref_w_ok <= 1'b0;
      incons   <= 1'b0;
`ifdef VIDEO_TIMING_DETECTOR_TOTALS_EN
      ref_t    <= '0;
      ref_t_ok <= 1'b0;
`endif
    end else begin
      v_cnt    <= f_v;
      act_cnt  <= f_act;
      ref_w    <= f_rw;
      ref_w_ok <= f_rw_ok;
      incons   <= f_inc;
`ifdef VIDEO_TIMING_DETECTOR_TOTALS_EN
      ref_t    <= f_rt;
      ref_t_ok <= f_rt_ok;
`endif
    end
  end

  // Lock FSM; measurement outputs load only on entry to LOCKED and hold after lock loss.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state     <= SEARCH;
      match_cnt <= '0;
      prev_ok   <= 1'b0;
      prev_w    <= '0;
      prev_h    <= '0;
      o_Locked  <= 1'b0;
      o_Width   <= '0;
      o_Height  <= '0;
`ifdef VIDEO_TIMING_DETECTOR_TOTALS_EN
      prev_ht   <= '0;
      prev_vt   <= '0;
      o_HTotal  <= '0;
      o_VTotal  <= '0;
`endif
    end else if (timeout) begin
      state     <= SEARCH;
      match_cnt <= '0;
      prev_ok   <= 1'b0;
      o_Locked  <= 1'b0;
    end else if (vs_start) begin
      prev_w  <= f_rw;
      prev_h  <= f_act;
      prev_ok <= frame_ok;
`ifdef VIDEO_TIMING_DETECTOR_TOTALS_EN
      prev_ht <= f_rt;
      prev_vt <= f_v;
`endif
      case (state)
        SEARCH: begin
          state   <= MEASURE;
          prev_ok <= 1'b0;
        end
        MEASURE: begin
          // With no valid predecessor a consistent frame starts a new run of matches.
          if (frame_ok && (frame_eq || !prev_ok)) begin
            match_cnt <= match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_N) begin
              state    <= LOCKED;
              o_Locked <= 1'b1;
              o_Width  <= f_rw;
              o_Height <= f_act;
`ifdef VIDEO_TIMING_DETECTOR_TOTALS_EN
              o_HTotal <= f_rt;
              o_VTotal <= f_v;
`endif
            end
          end else begin
            match_cnt <= '0;
          end
        end
        LOCKED: begin
          if (!(frame_ok && frame_eq)) begin
            state     <= MEASURE;
            match_cnt <= '0;
            o_Locked  <= 1'b0;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

`ifndef VIDEO_TIMING_DETECTOR_TOTALS_EN
  assign o_HTotal = '0;
  assign o_VTotal = '0;
`endif
endmodule

// File: tb/tb_video_timing_detector.sv
// Scoreboard bench for video_timing_detector using a reduced 40x30 (32x24 active) raster;
// expectations follow VIDEO_TIMING_DETECTOR_TOTALS_EN when the bench is compiled with it.
module tb_video_timing_detector;
`ifdef VIDEO_TIMING_DETECTOR_TOTALS_EN
  localparam bit TOT = 1'b1;
`else
  localparam bit TOT = 1'b0;
`endif

  typedef struct packed {
    logic        locked;
    logic [11:0] w;
    logic [11:0] h;
    logic [11:0] ht;
    logic [11:0] vt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        n_hsync = 1'b1, n_vsync = 1'b1, hblank = 1'b1, vblank = 1'b1;
  logic        locked;
  logic [11:0] width, height, htotal, vtotal;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  video_timing_detector #(.C_COUNT_WIDTH(12), .C_LOCK_FRAMES(2)) dut (
    .i_Clk(clk), .i_nRst(rst_n), .i_nHSync(n_hsync), .i_nVSync(n_vsync),
    .i_HBlank(hblank), .i_VBlank(vblank), .o_Locked(locked),
    .o_Width(width), .o_Height(height), .o_HTotal(htotal), .o_VTotal(vtotal)
  );

  function automatic exp_t mk(input logic l, input int w, input int h, input int ht, input int vt);
    mk.locked = l;
    mk.w      = 12'(w);
    mk.h      = 12'(h);
    mk.ht     = TOT ? 12'(ht) : 12'd0;
    mk.vt     = TOT ? 12'(vt) : 12'd0;
  endfunction

  // One frame: hsync low for 4 clocks at each line start, vsync low for lines 0-1, hblank
  // for pixels >= w, vblank for lines >= h. Unless no_start, the frame opens with a
  // simultaneous hsync/vsync fall whose outcome e is pushed and checked two clocks later.
  task automatic frame(input int ht, input int w, input int vt, input int h,
                       input int n_lines, input bit no_start, input exp_t e);
    exp_t got;
    for (int ln = 0; ln < n_lines; ln++) begin
      for (int px = 0; px < ht; px++) begin
        @(negedge clk);
        if (!no_start && ln == 0 && px == 2) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: queue empty, required 1 entry");
          end else begin
            got = sb.pop_front();
            checks++;
            if (locked !== got.locked) begin errors++; $display("FAIL locked: got %0b required %0b", locked, got.locked); end
            checks++;
            if (width !== got.w) begin errors++; $display("FAIL width: got %0d required %0d", width, got.w); end
            checks++;
            if (height !== got.h) begin errors++; $display("FAIL height: got %0d required %0d", height, got.h); end
            checks++;
            if (htotal !== got.ht) begin errors++; $display("FAIL htotal: got %0d required %0d", htotal, got.ht); end
            checks++;
            if (vtotal !== got.vt) begin errors++; $display("FAIL vtotal: got %0d required %0d", vtotal, got.vt); end
          end
        end
        if (!no_start && ln == 0 && px == 0) sb.push_back(e);
        n_hsync = !(px < 4);
        n_vsync = !(ln < 2);
        hblank  = (px >= w);
        vblank  = (ln >= h);
        if (no_start && ln == 0 && px == 0) rst_n = 1'b1;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL %s locked: got %0b required 0", tag, locked); end
    checks++;
    if (width !== 12'd0) begin errors++; $display("FAIL %s width: got %0d required 0", tag, width); end
    checks++;
    if (height !== 12'd0) begin errors++; $display("FAIL %s height: got %0d required 0", tag, height); end
    checks++;
    if (htotal !== 12'd0) begin errors++; $display("FAIL %s htotal: got %0d required 0", tag, htotal); end
    checks++;
    if (vtotal !== 12'd0) begin errors++; $display("FAIL %s vtotal: got %0d required 0", tag, vtotal); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
  endtask

  // Discarded frame, first measured frame, then lock at the third vsync start.
  task automatic test_lock();
    frame(40, 32, 30, 24, 30, 1'b0, mk(1'b0, 0, 0, 0, 0));
    frame(40, 32, 30, 24, 30, 1'b0, mk(1'b0, 0, 0, 0, 0));
    frame(40, 32, 30, 24, 30, 1'b0, mk(1'b1, 32, 24, 40, 30));
  endtask

  task automatic test_width_change();
    frame(40, 16, 30, 24, 30, 1'b0, mk(1'b1, 32, 24, 40, 30));
    frame(40, 16, 30, 24, 30, 1'b0, mk(1'b0, 32, 24, 40, 30));
    frame(40, 16, 30, 24, 30, 1'b0, mk(1'b0, 32, 24, 40, 30));
    frame(40, 16, 30, 24, 30, 1'b0, mk(1'b1, 16, 24, 40, 30));
  endtask

  task automatic test_timeout();
    n_hsync = 1'b1;
    n_vsync = 1'b1;
    repeat (4100) @(negedge clk);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL timeout locked: got %0b required 0", locked); end
    checks++;
    if (width !== 12'd16) begin errors++; $display("FAIL timeout width held: got %0d required 16", width); end
    frame(40, 16, 30, 24, 30, 1'b0, mk(1'b0, 16, 24, 40, 30));
    frame(40, 16, 30, 24, 30, 1'b0, mk(1'b0, 16, 24, 40, 30));
    frame(40, 16, 30, 24, 30, 1'b0, mk(1'b1, 16, 24, 40, 30));
  endtask

  // Reset mid-frame while locked, released with both syncs already low.
  task automatic test_async_reset();
    frame(40, 16, 30, 24, 10, 1'b0, mk(1'b1, 16, 24, 40, 30));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    n_hsync = 1'b0;
    n_vsync = 1'b0;
    repeat (3) @(negedge clk);
    frame(40, 32, 30, 24, 30, 1'b1, mk(1'b0, 0, 0, 0, 0));
    frame(40, 32, 30, 24, 30, 1'b0, mk(1'b0, 0, 0, 0, 0));
    frame(40, 32, 30, 24, 30, 1'b0, mk(1'b0, 0, 0, 0, 0));
    frame(40, 32, 30, 24, 30, 1'b0, mk(1'b1, 32, 24, 40, 30));
  endtask

  // Line total alternates 40/42 with fixed active size: lock survives only without totals.
  task automatic test_htotal_alternate();
    frame(42, 32, 30, 24, 30, 1'b0, mk(1'b1, 32, 24, 40, 30));
    frame(40, 32, 30, 24, 30, 1'b0, mk(!TOT, 32, 24, 40, 30));
    frame(42, 32, 30, 24, 30, 1'b0, mk(!TOT, 32, 24, 40, 30));
    frame(40, 32, 30, 24, 30, 1'b0, mk(!TOT, 32, 24, 40, 30));
  endtask

  initial begin
    test_reset();
    test_lock();
    test_width_change();
    test_timeout();
    test_async_reset();
    test_htotal_alternate();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard drain: got %0d entries required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
